imem_loader: RTL and testbench

- Instruction-memory writer for the single-cycle MIPS core. It is the producer end of the instruction path; the core's fetch and decode logic is the consumer.
- Accepts a byte stream over a valid/ready handshake from a UART receiver or host bridge. Assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory from word address 0.
- Holds the core in reset for the whole load and releases it once the last word has been written.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR_HI = 3'd1;
    localparam logic [2:0] ST_HDR_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Big-endian 4-byte shift register; full marks the 4th shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en_i,
    input  logic        clr_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clr_i) begin
            idx_q  <= 2'd0;
        end else if (shift_en_i) begin
            word_q <= {word_q[23:0], byte_i};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign word_o = word_q;
    assign full_o = shift_en_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Loads a length-prefixed byte stream into instruction memory
//               and holds the core in reset until the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       wdata_q;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;

    logic              w_hs;
    logic [15:0]       w_n_full;
    logic              w_last;
    logic [31:0]       w_pk_word;
    logic              w_pk_full;

    assign w_hs     = byte_valid && ready_q;
    assign w_n_full = {n_q[15:8], byte_in};
    assign w_last   = (17'(cnt_q) + 17'd1) == {1'b0, n_q};

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (w_hs && (state_q == ST_DATA)),
        .clr_i      (w_hs && (state_q == ST_HDR_LO)),
        .byte_i     (byte_in),
        .word_o     (w_pk_word),
        .full_o     (w_pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= 16'd0;
            addr_q      <= '0;
            cnt_q       <= '0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            if (state_q == ST_WRITE) begin
                wdata_q <= w_pk_word;
            end
            ready_q     <= ready_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_hs) begin
                    n_d[15:8] = byte_in;
                    state_d   = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (w_hs) begin
                    n_d = w_n_full;
                    if (w_n_full == 16'd0) begin
                        state_d = ST_DONE;
                    end else if ({1'b0, w_n_full} > CAP) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                        addr_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (w_pk_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Address is not advanced past the final word, so it never wraps.
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DATA;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + (ADDR_W + 1)'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_d     = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) || (state_d == ST_DATA);
        we_d        = (state_d == ST_WRITE);
        busy_d      = ready_d || we_d;
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
        cpu_rst_n_d = (state_d == ST_DONE);
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = we_q ? w_pk_word : wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
    import mips_pkg::*;

    localparam int ADDR_W = 8;
    localparam int HB     = int'(HDR_BYTES);
    localparam int BPW    = int'(BYTES_PER_WORD);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_words [256];
    logic [31:0] seen_data [256];
    int          acc       = 0;
    logic        exp_we    = 1'b0;
    int          exp_addr  = 0;
    int          wr_count  = 0;
    int          wr_addr0  = 0;
    int          last_addr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Stream-level model: every 4th data byte accepted must be followed next cycle by its write.
    always @(negedge clk) begin
        chk("we_timing", {31'd0, imem_we}, {31'd0, exp_we});
        if (imem_we) begin
            chk("wr_addr", 32'(imem_addr), 32'(exp_addr));
            chk("wr_data", imem_wdata, exp_words[exp_addr]);
            chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
            seen_data[imem_addr] = imem_wdata;
            wr_count++;
            if (imem_addr == '0) wr_addr0++;
            last_addr = int'(imem_addr);
        end
        exp_we = 1'b0;
        if (!rst_n) begin
            acc = 0;
        end else begin
            if (start) acc = 0;
            if (byte_valid && byte_ready) begin
                acc++;
                if (acc > HB && ((acc - HB) % BPW) == 0) begin
                    exp_we   = 1'b1;
                    exp_addr = (acc - HB) / BPW - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted = 0;
        int n = 0;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        while (!accepted && n < 50) begin
            @(negedge clk);
            if (byte_ready) accepted = 1;
            tick();
            n++;
        end
        byte_valid = 1'b0;
        if (!accepted) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // First byte of each word goes out with no gap so it lands during WRITE.
    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], (i == 0 || gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        chk("start_done_clr", {31'd0, done}, 32'd0);
        chk("start_err_clr", {31'd0, err}, 32'd0);
        tick();
    endtask

    task automatic run_load(input logic [15:0] n, input int gapmax);
        pulse_start();
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        for (int w = 0; w < int'(n); w++) send_word(exp_words[w], gapmax);
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("end_reached", {31'd0, done || err}, 32'd1);
    endtask

    task automatic clear_stats();
        wr_count  = 0;
        wr_addr0  = 0;
        last_addr = -1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
    endtask

    task automatic chk_done_state(input int nwords);
        chk("done_flag", {31'd0, done}, 32'd1);
        chk("done_cpu_rst", {31'd0, cpu_rst_n}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_err", {31'd0, err}, 32'd0);
        chk("write_count", 32'(wr_count), 32'(nwords));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic two-word load
        exp_words[0] = 32'h24080005;
        exp_words[1] = 32'hAC080000;
        clear_stats();
        run_load(16'd2, 0);
        wait_end();
        chk_done_state(2);
        chk("basic_w0", seen_data[0], 32'h24080005);
        chk("basic_w1", seen_data[1], 32'hAC080000);
        tick();

        // Empty program
        clear_stats();
        run_load(16'd0, 0);
        wait_end();
        chk_done_state(0);
        tick();

        // Oversize header 0x0101 > 256
        clear_stats();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd0);
        chk("ovf_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        chk("ovf_ready", {31'd0, byte_ready}, 32'd0);
        chk("ovf_done", {31'd0, done}, 32'd0);
        tick();
        run_load(16'd0, 0);
        wait_end();
        chk_done_state(0);
        tick();

        // Stalls and bytes held during WRITE
        exp_words[0] = 32'h01234567;
        exp_words[1] = 32'h89ABCDEF;
        exp_words[2] = 32'hDEADBEEF;
        exp_words[3] = 32'h00000000;
        exp_words[4] = 32'hFFFFFFFF;
        clear_stats();
        run_load(16'd5, 3);
        wait_end();
        chk_done_state(5);
        chk("stall_w2", seen_data[2], 32'hDEADBEEF);
        chk("stall_w4", seen_data[4], 32'hFFFFFFFF);
        tick();

        // Full capacity
        for (int i = 0; i < 256; i++) begin
            exp_words[i] = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
        end
        clear_stats();
        run_load(16'd256, 0);
        wait_end();
        chk_done_state(256);
        chk("full_last_addr", 32'(last_addr), 32'h000000FF);
        chk("full_addr0_once", 32'(wr_addr0), 32'd1);
        chk("full_w255", seen_data[255], 32'hFF005A3C);
        tick();

        // Asynchronous reset after 6 data bytes
        exp_words[0] = 32'h24080005;
        exp_words[1] = 32'hAC080000;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(exp_words[0], 0);
        send_byte(8'hAC, 0);
        send_byte(8'h08, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        run_load(16'd2, 0);
        wait_end();
        chk_done_state(2);
        chk("rerun_w0", seen_data[0], 32'h24080005);
        chk("rerun_w1", seen_data[1], 32'hAC080000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
